matrix_column_writer: RTL

//  Write-side counterpart of the 5x7 matrix column-select mux.

---
 rtl/matrix_column_writer.sv | 85 ++++++++
 1 files changed

// File: rtl/matrix_column_writer.sv
// Collects one ROWS-bit column word per handshake into a shadow frame and commits
// the whole frame to frame_data in a single cycle once the last column lands.
module matrix_column_writer #(
  parameter int ROWS = 5,
  parameter int COLS = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   col_valid,
  output logic                   col_ready,
  input  logic [ROWS-1:0]        col_data,
  input  logic                   col_last,
  input  logic                   clear,
  output logic [2:0]             wr_sel,
  output logic [ROWS*COLS-1:0]   frame_data,
  output logic                   frame_valid,
  output logic                   frame_err
);

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t                 state;
  logic [ROWS*COLS-1:0]   shadow;
  logic                   accept;

  // Handshake: a column transfers on a rising edge where col_valid and col_ready
  // are both high; col_ready is a registered function of the state alone.
  assign accept = col_valid && col_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FILL;
      col_ready   <= 1'b1;
      wr_sel      <= 3'd1;
      shadow      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        FILL: begin
          if (clear) begin
            wr_sel <= 3'd1;
          end else if (accept) begin
            // Column k lands at bit r*COLS + k-1, the same map the scan mux reads.
            for (int c = 0; c < COLS; c++) begin
              if (wr_sel == 3'(c + 1)) begin
                for (int r = 0; r < ROWS; r++) begin
                  shadow[r*COLS + c] <= col_data[r];
                end
              end
            end
            if (wr_sel == 3'(COLS)) begin
              state     <= COMMIT;
              col_ready <= 1'b0;
              wr_sel    <= 3'd1;
            end else if (col_last) begin
              frame_err <= 1'b1;
              wr_sel    <= 3'd1;
            end else begin
              wr_sel <= wr_sel + 3'd1;
            end
          end
        end
        COMMIT: begin
          // The frame is already whole here, so clear has nothing left to discard.
          frame_data  <= shadow;
          frame_valid <= 1'b1;
          state       <= FILL;
          col_ready   <= 1'b1;
        end
        default: begin
          state     <= FILL;
          col_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
